pdm_tx: RTL and testbench

PCM-to-PDM transmitter for the uDMA I2S peripheral: the output-direction counterpart of the PDM receive/decimation path. Takes 16-bit signed PCM samples from the TX FIFO (valid/ready), holds each sample for a programmable number of clock cycles (zero-order-hold interpolation), and drives one or two 1-bit PDM streams through a second-order sigma-delta modulator. The PDM bit clock is `clk_i` itself, forwarded externally.

---
 rtl/pdm_tx_pkg.sv | 37 +++
 rtl/pdm_tx_sdm.sv | 62 ++++++
 rtl/pdm_tx.sv | 162 ++++++++++++++++
 tb/tb_pdm_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_tx_pkg.sv
// Shared types, constants and arithmetic helpers for the PCM-to-PDM transmitter.
// Imported by the top level and by the sigma-delta modulator.
package pdm_tx_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int ACC_W_DEF    = 24;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_RUN        = 2'd2
    } state_e;

    localparam logic [1:0] MODE_MONO   = 2'b00;
    localparam logic [1:0] MODE_STEREO = 2'b01;
    localparam logic [1:0] MODE_DUAL   = 2'b10;

    // Widths up to about 29 bits fit, so the 3-term sums never wrap in 32 bits.
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v,
                                                     input int                 w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic ch1_enabled(input logic [1:0] mode);
        return (mode == MODE_STEREO) || (mode == MODE_DUAL);
    endfunction

endpackage

// File: rtl/pdm_tx_sdm.sv
// Second-order sigma-delta modulator with saturating integrators and a
// registered 1-bit output. clr_i wipes all state; en_i advances one bit.
module pdm_sdm
    import pdm_tx_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [ACC_W-1:0] x_i,
    output logic                    y_o
);

    localparam logic signed [31:0] FB_MAG = 32'sd1 <<< (SAMPLE_W - 1);

    logic signed [ACC_W-1:0] i1_q, i1_d;
    logic signed [ACC_W-1:0] i2_q, i2_d;
    logic                    y_q, y_d;
    logic                    y_now;
    logic signed [31:0]      fb;
    logic signed [31:0]      sum1, sum2, sat1, sat2;

    always_comb begin
        // The quantiser decides from the current second integrator sign.
        y_now = ~i2_q[ACC_W-1];
        fb    = y_now ? FB_MAG : -FB_MAG;
        sum1  = 32'(i1_q) + 32'(x_i) - fb;
        sat1  = sat_clamp(sum1, ACC_W);
        sum2  = 32'(i2_q) + sat1 - fb;
        sat2  = sat_clamp(sum2, ACC_W);

        i1_d = i1_q;
        i2_d = i2_q;
        y_d  = 1'b0;
        if (clr_i) begin
            i1_d = '0;
            i2_d = '0;
        end else if (en_i) begin
            i1_d = ACC_W'(sat1);
            i2_d = ACC_W'(sat2);
            y_d  = y_now;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            i1_q <= '0;
            i2_q <= '0;
            y_q  <= 1'b0;
        end else begin
            i1_q <= i1_d;
            i2_q <= i2_d;
            y_q  <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/pdm_tx.sv
// PCM-to-PDM transmitter: one-word input buffer, zero-order hold of each sample
// for cfg_pdm_interp_i+1 clocks, and one or two sigma-delta bitstreams.
module pdm_tx
    import pdm_tx_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cfg_pdm_en_i,
    input  logic [1:0]  cfg_pdm_ch_mode_i,
    input  logic [9:0]  cfg_pdm_interp_i,
    input  logic [2:0]  cfg_pdm_shift_i,
    input  logic [31:0] pcm_data_i,
    input  logic        pcm_data_valid_i,
    output logic        pcm_data_ready_o,
    output logic        pdm_ch0_o,
    output logic        pdm_ch1_o,
    output logic        underrun_o,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a word moves on any rising edge where valid and ready are both
    // high. Ready depends only on registered state, never on valid.

    state_e                     state_q, state_d;
    logic [9:0]                 cnt_q, cnt_d;
    logic [31:0]                buf_q, buf_d;
    logic                       buf_full_q, buf_full_d;
    logic signed [SAMPLE_W-1:0] hold0_q, hold0_d;
    logic signed [SAMPLE_W-1:0] hold1_q, hold1_d;
    logic                       underrun;
    logic                       xfer;
    logic                       ch1_on;
    logic signed [SAMPLE_W-1:0] buf_ch0, buf_ch1;

    assign ch1_on           = ch1_enabled(cfg_pdm_ch_mode_i);
    assign pcm_data_ready_o = (state_q != ST_IDLE) && !buf_full_q;
    assign xfer             = pcm_data_valid_i && pcm_data_ready_o;

    always_comb begin
        buf_ch0 = buf_q[SAMPLE_W-1:0];
        buf_ch1 = '0;
        if (cfg_pdm_ch_mode_i == MODE_STEREO) begin
            buf_ch1 = buf_q[16 +: SAMPLE_W];
        end else if (cfg_pdm_ch_mode_i == MODE_DUAL) begin
            buf_ch1 = buf_q[SAMPLE_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        hold0_d    = hold0_q;
        hold1_d    = hold1_q;
        underrun   = 1'b0;

        if (!cfg_pdm_en_i) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            buf_d      = '0;
            buf_full_d = 1'b0;
            hold0_d    = '0;
            hold1_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: begin
                    if (buf_full_q) begin
                        state_d    = ST_RUN;
                        hold0_d    = buf_ch0;
                        hold1_d    = buf_ch1;
                        buf_full_d = 1'b0;
                        cnt_d      = cfg_pdm_interp_i;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == '0) begin
                        cnt_d = cfg_pdm_interp_i;
                        if (buf_full_q) begin
                            hold0_d    = buf_ch0;
                            hold1_d    = buf_ch1;
                            buf_full_d = 1'b0;
                        end else begin
                            // Starved period: emit silence rather than repeat.
                            hold0_d  = '0;
                            hold1_d  = '0;
                            underrun = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (xfer) begin
                buf_d      = pcm_data_i;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            hold0_q    <= '0;
            hold1_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            hold0_q    <= hold0_d;
            hold1_q    <= hold1_d;
        end
    end

    logic                    sdm_clr0, sdm_clr1, sdm_run;
    logic signed [ACC_W-1:0] x0, x1;

    // Dropping enable clears the modulators on the same edge, so outputs fall
    // to zero one cycle after enable goes low.
    assign sdm_clr0 = !cfg_pdm_en_i || (state_q == ST_IDLE);
    assign sdm_clr1 = sdm_clr0 || !ch1_on;
    assign sdm_run  = (state_q == ST_RUN);

    assign x0 = $signed({{(ACC_W-SAMPLE_W){hold0_q[SAMPLE_W-1]}}, hold0_q}) >>> cfg_pdm_shift_i;
    assign x1 = $signed({{(ACC_W-SAMPLE_W){hold1_q[SAMPLE_W-1]}}, hold1_q}) >>> cfg_pdm_shift_i;

    pdm_sdm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_sdm_ch0 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (sdm_clr0),
        .en_i   (sdm_run),
        .x_i    (x0),
        .y_o    (pdm_ch0_o)
    );

    pdm_sdm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_sdm_ch1 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (sdm_clr1),
        .en_i   (sdm_run),
        .x_i    (x1),
        .y_o    (pdm_ch1_o)
    );

    assign underrun_o  = underrun;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: cycle-level reference model built from the
// hold-period and modulator equations, plus directed checks of key behaviours.
module tb_pdm_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [1:0]  mode;
  logic [9:0]  interp;
  logic [2:0]  shift;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        ch0;
  logic        ch1;
  logic        underrun;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  pdm_tx dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .cfg_pdm_en_i      (en),
    .cfg_pdm_ch_mode_i (mode),
    .cfg_pdm_interp_i  (interp),
    .cfg_pdm_shift_i   (shift),
    .pcm_data_i        (data),
    .pcm_data_valid_i  (valid),
    .pcm_data_ready_o  (ready),
    .pdm_ch0_o         (ch0),
    .pdm_ch1_o         (ch1),
    .underrun_o        (underrun),
    .dbg_state_o       (dbg_state)
  );

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_on;
  bit m_started;
  int m_age;
  int m_buf[$];
  int m_h0, m_h1;
  int m_i1[2];
  int m_i2[2];
  bit m_out[2];
  int m_xfers = 0;
  int m_unders = 0;
  int d_xfers = 0;
  int d_unders = 0;

  function automatic int clamp24(input int v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic int period();
    return int'(interp) + 1;
  endfunction

  function automatic bit m_ready();
    return m_on && (m_buf.size() == 0);
  endfunction

  function automatic bit m_under();
    return m_started && (m_age == period() - 1) && (m_buf.size() == 0);
  endfunction

  task automatic model_clear();
    m_on = 0; m_started = 0; m_age = 0; m_buf.delete();
    m_h0 = 0; m_h1 = 0;
    for (int c = 0; c < 2; c++) begin
      m_i1[c] = 0; m_i2[c] = 0; m_out[c] = 0;
    end
  endtask

  task automatic model_load(input int word);
    logic [31:0] w;
    w = word;
    m_h0 = int'($signed(w[15:0]));
    if (mode == 2'b01)      m_h1 = int'($signed(w[31:16]));
    else if (mode == 2'b10) m_h1 = m_h0;
    else                    m_h1 = 0;
  endtask

  task automatic model_mod(input int c, input int h);
    bit y;
    int fb, x;
    y  = (m_i2[c] >= 0);
    fb = y ? 32768 : -32768;
    x  = h >>> shift;
    m_i1[c] = clamp24(m_i1[c] + x - fb);
    m_i2[c] = clamp24(m_i2[c] + m_i1[c] - fb);
    m_out[c] = y;
  endtask

  task automatic model_step();
    bit xfer;
    if (!rstn || !en) begin
      model_clear();
    end else if (!m_on) begin
      m_on = 1;
    end else begin
      xfer = valid && m_ready();
      if (!m_started) begin
        m_out[0] = 0; m_out[1] = 0;
        if (m_buf.size() > 0) begin
          model_load(m_buf.pop_front());
          m_started = 1;
          m_age = 0;
        end
      end else begin
        model_mod(0, m_h0);
        if (mode == 2'b01 || mode == 2'b10) model_mod(1, m_h1);
        else m_out[1] = 0;
        if (m_age == period() - 1) begin
          if (m_buf.size() > 0) model_load(m_buf.pop_front());
          else begin model_load(0); m_unders++; end
          m_age = 0;
        end else begin
          m_age++;
        end
      end
      if (xfer) begin
        m_buf.push_back(int'(data));
        m_xfers++;
      end
    end
  endtask

  // Called at a falling edge with inputs already set; compares, advances.
  task automatic tick();
    chk("ch0", ch0, m_out[0]);
    chk("ch1", ch1, m_out[1]);
    chk("ready", ready, m_ready());
    chk("underrun", underrun, m_under());
    if (valid && ready) d_xfers++;
    if (underrun) d_unders++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_started(input int limit);
    int n = 0;
    while (!m_started && n < limit) begin
      tick();
      n++;
    end
    chk("start_timeout", m_started, 1);
  endtask

  task automatic disable_block();
    en = 0; valid = 0;
    tick();
    tick();
  endtask

  int ones0, ones1, ubase, xbase, dubase, dxbase;
  logic [3:0] first4;

  initial begin
    rstn = 0; en = 0; mode = 0; interp = 0; shift = 0; data = 0; valid = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ch0", ch0, 0);
    chk("rst_ch1", ch1, 0);
    chk("rst_ready", ready, 0);
    chk("rst_underrun", underrun, 0);
    rstn = 1;
    for (int k = 0; k < 100; k++) tick();

    // Zero input, mono, P=16: exact 1,0,0,1 pattern.
    mode = 2'b00; interp = 10'd15; shift = 0; data = 0; valid = 1; en = 1;
    wait_started(50);
    tick();
    ones0 = 0; ones1 = 0;
    for (int k = 0; k < 64; k++) begin
      if (k < 4) first4[3-k] = ch0;
      ones0 += int'(ch0);
      ones1 += int'(ch1);
      tick();
    end
    chk("zero_pattern", first4, 4'b1001);
    chk("zero_ones64", ones0, 32);
    chk("zero_ch1_ones", ones1, 0);

    // Stereo +0.5 / -0.5, P=64.
    disable_block();
    mode = 2'b01; interp = 10'd63; shift = 0; data = 32'hC000_4000; valid = 1; en = 1;
    wait_started(50);
    tick();
    ones0 = 0; ones1 = 0;
    for (int k = 0; k < 1024; k++) begin
      ones0 += int'(ch0);
      ones1 += int'(ch1);
      tick();
    end
    chk("stereo_ch0_density", (ones0 >= 766 && ones0 <= 770), 1);
    chk("stereo_ch1_density", (ones1 >= 254 && ones1 <= 258), 1);

    // Two words then starve, P=8.
    disable_block();
    mode = 2'b00; interp = 10'd7; shift = 3'($urandom_range(0, 7)); en = 1;
    xbase = m_xfers; ubase = m_unders; dubase = d_unders;
    for (int k = 0; k < 120; k++) begin
      valid = (m_xfers - xbase) < 2;
      data  = $urandom;
      tick();
    end
    chk("under_words", m_xfers - xbase, 2);
    chk("under_count", d_unders - dubase, m_unders - ubase);

    // Backpressure: valid always high, dual mode, P=5.
    disable_block();
    mode = 2'b10; interp = 10'd4; shift = 3'($urandom_range(0, 7)); en = 1; valid = 1;
    xbase = m_xfers; dxbase = d_xfers;
    for (int k = 0; k < 300; k++) begin
      data = $urandom;
      tick();
    end
    chk("bp_xfers", d_xfers - dxbase, m_xfers - xbase);

    // Randomised configurations and traffic.
    for (int r = 0; r < 4; r++) begin
      disable_block();
      mode = 2'($urandom_range(0, 3));
      interp = 10'($urandom_range(0, 5));
      shift = 3'($urandom_range(0, 7));
      en = 1;
      for (int k = 0; k < 150; k++) begin
        valid = ($urandom_range(0, 9) < 7);
        data  = $urandom;
        if ($urandom_range(0, 99) == 0) en = 0; else en = 1;
        tick();
      end
    end

    // Disable mid-period, then restart from clean integrators.
    disable_block();
    mode = 2'b00; interp = 10'd7; shift = 0; en = 1; valid = 1; data = $urandom;
    wait_started(50);
    for (int k = 0; k < 5; k++) begin
      data = $urandom;
      tick();
    end
    en = 0;
    tick();
    chk("dis_ch0", ch0, 0);
    chk("dis_ready", ready, 0);
    valid = 0;
    tick();
    en = 1;
    for (int k = 0; k < 20; k++) tick();
    valid = 1; data = 32'h0;
    wait_started(50);
    tick();
    chk("restart_first_bit", ch0, 1);
    for (int k = 0; k < 10; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
